// File: rtl/freq_mon_pkg.sv
// Shared definitions for the divided-clock frequency monitor: FSM encodings,
// default expected period/tolerance and a small unsigned distance helper.
package freq_mon_pkg;

    localparam logic [0:0] S_WAIT = 1'b0;
    localparam logic [0:0] S_MEAS = 1'b1;

    localparam int DEF_EXP_PERIOD = 3;
    localparam int DEF_TOL        = 0;

    // Distance between two unsigned values without wrap-around.
    function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/freq_mon_edge.sv
// Samples the divided clock as data and flags its rising edges.
// FREQ_MON_SYNC_EN adds a 2-flop synchronizer ahead of the sampling register.
module freq_mon_edge (
    input  logic clk,
    input  logic rst,
    input  logic div_in,
    output logic div_s,
    output logic rise
);

    logic div_d;

`ifdef FREQ_MON_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], div_in};
        end
    end

    always_ff @(posedge clk) begin
        div_s <= sync[1];
    end
`else
    always_ff @(posedge clk) begin
        div_s <= div_in;
    end
`endif

    // Delayed copy comes out of reset high so a line already high is not a rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_d <= 1'b1;
        end else begin
            div_d <= div_s;
        end
    end

    assign rise = div_s & ~div_d;

endmodule

// File: rtl/freq_monitor.sv
// Measures period and high time of the divided clock, judges the period against
// EXP_PERIOD +/- TOL, and reports lock, error and timeout (optional FREQ_MON_SYNC_EN).
module freq_monitor
    import freq_mon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = 4,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int                LR_W        = $clog2(LOCK_CNT + 1);
    localparam logic [LR_W-1:0]   LOCK_TARGET = LR_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
    localparam int unsigned       EXP_U       = EXP_PERIOD;
    localparam int unsigned       TOL_U       = TOL;

    logic             div_s;
    logic             rise;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [LR_W-1:0]  lock_run;

    logic             in_tol;
    logic [LR_W-1:0]  lock_run_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcnt_inc;
    logic [ERR_W-1:0] err_cnt_inc;

    freq_mon_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .div_in (div_in),
        .div_s  (div_s),
        .rise   (rise)
    );

    // Saturating next values and the tolerance judgement of the running count.
    always_comb begin
        in_tol       = abs_diff(32'(cnt), EXP_U) <= TOL_U;
        lock_run_inc = (lock_run == LOCK_TARGET) ? LOCK_TARGET : lock_run + LR_W'(1);
        cnt_inc      = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
        hcnt_inc     = (hcnt == CNT_MAX || !div_s) ? hcnt : hcnt + CNT_ONE;
        err_cnt_inc  = (err_cnt == ERR_MAX) ? ERR_MAX : err_cnt + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_WAIT;
            cnt        <= '0;
            hcnt       <= '0;
            lock_run   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            meas_valid <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                S_WAIT: begin
                    // The first edge only opens a measurement window.
                    if (rise) begin
                        state <= S_MEAS;
                        cnt   <= CNT_ONE;
                        hcnt  <= CNT_ONE;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hcnt;
                        meas_valid <= 1'b1;
                        cnt        <= CNT_ONE;
                        hcnt       <= CNT_ONE;
                        if (in_tol) begin
                            lock_run <= lock_run_inc;
                            locked   <= (lock_run_inc == LOCK_TARGET);
                        end else begin
                            err      <= 1'b1;
                            lock_run <= '0;
                            locked   <= 1'b0;
                            err_cnt  <= err_cnt_inc;
                        end
                    end else if (cnt == CNT_MAX) begin
                        // Edge never arrived: give up and wait for a fresh reference edge.
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        lock_run <= '0;
                        err_cnt  <= err_cnt_inc;
                        cnt      <= '0;
                        hcnt     <= '0;
                        state    <= S_WAIT;
                    end else begin
                        cnt  <= cnt_inc;
                        hcnt <= hcnt_inc;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_monitor.sv
// Self-checking bench for freq_monitor: timestamp-based reference model plus
// directed patterns with hand-computed sticky expectations.
module tb_freq_monitor;

    localparam int CNT_W    = 8;
    localparam int EXP_P    = 3;
    localparam int TOL_V    = 0;
    localparam int LOCK_N   = 4;
    localparam int ERR_MAXV = 15;
    localparam int CNT_MAXV = 255;
`ifdef FREQ_MON_SYNC_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 1;
`endif

    logic             clk;
    logic             rst;
    logic             div_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic             timeout;
    logic [3:0]       err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit ready    = 0;

    freq_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .div_in     (div_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err        (err),
        .timeout    (timeout),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: measurements are differences between rise timestamps.
    int line [3];
    bit prev_s;
    bit m_meas;
    int last_rise;
    int hsum;
    int m_lr;
    int e_period, e_high, e_valid, e_locked, e_err, e_to, e_ec;

    always @(posedge clk) begin
        bit s;
        bit r;
        int p;
        int d;
        cyc++;
        if (!rst) begin
            m_meas = 0; m_lr = 0;
            e_period = 0; e_high = 0; e_valid = 0; e_locked = 0;
            e_err = 0; e_to = 0; e_ec = 0;
            prev_s = 1;
            for (int i = 0; i < 3; i++) line[i] = 0;
            if (DLY == 1) line[0] = int'(div_in);
            ready = 1;
        end else begin
            s = (line[DLY-1] != 0);
            for (int i = DLY - 1; i > 0; i--) line[i] = line[i-1];
            line[0] = int'(div_in);
            r = s && !prev_s;
            prev_s = s;
            e_valid = 0; e_err = 0; e_to = 0;
            if (!m_meas) begin
                if (r) begin
                    m_meas = 1; last_rise = cyc; hsum = 1;
                end
            end else if (r) begin
                p = cyc - last_rise;
                e_period = p; e_high = hsum; e_valid = 1;
                d = (p >= EXP_P) ? p - EXP_P : EXP_P - p;
                if (d <= TOL_V) begin
                    m_lr = (m_lr < LOCK_N) ? m_lr + 1 : LOCK_N;
                    e_locked = (m_lr == LOCK_N) ? 1 : 0;
                end else begin
                    e_err = 1; m_lr = 0; e_locked = 0;
                    e_ec = (e_ec < ERR_MAXV) ? e_ec + 1 : ERR_MAXV;
                end
                last_rise = cyc; hsum = 1;
            end else if (cyc - last_rise == CNT_MAXV) begin
                e_to = 1; e_locked = 0; m_lr = 0; m_meas = 0;
                e_ec = (e_ec < ERR_MAXV) ? e_ec + 1 : ERR_MAXV;
            end else begin
                hsum += int'(s);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ready) begin
            checkOutput("period",     32'(period),     32'(e_period));
            checkOutput("high_time",  32'(high_time),  32'(e_high));
            checkOutput("meas_valid", 32'(meas_valid), 32'(e_valid));
            checkOutput("locked",     32'(locked),     32'(e_locked));
            checkOutput("err",        32'(err),        32'(e_err));
            checkOutput("timeout",    32'(timeout),    32'(e_to));
            checkOutput("err_cnt",    32'(err_cnt),    32'(e_ec));
        end
    end

    task automatic applyStimulus(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi + lo; i++) begin
                @(negedge clk);
                div_in = (i < hi) ? 1'b1 : 1'b0;
            end
        end
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0;
            div_in = ~div_in;
        end
        @(negedge clk);
        rst = 1'b1;
        div_in = 1'b0;
    endtask

    task automatic checkSticky(input string tag, input int p, input int h, input int lk, input int ec);
        checkOutput({tag, "_period"},    32'(period),    32'(p));
        checkOutput({tag, "_high_time"}, 32'(high_time), 32'(h));
        checkOutput({tag, "_locked"},    32'(locked),    32'(lk));
        checkOutput({tag, "_err_cnt"},   32'(err_cnt),   32'(ec));
    endtask

    initial begin
        rst = 1'b0;
        div_in = 1'b0;
        doReset(5);
        @(negedge clk);
        checkSticky("reset", 0, 0, 0, 0);

        applyStimulus(1, 2, 6);
        checkSticky("div3_lock", 3, 1, 1, 0);

        applyStimulus(1, 4, 3);
        checkSticky("div5", 5, 1, 0, 2);

        applyStimulus(1, 2, 6);
        checkSticky("relock", 3, 1, 1, 3);

        applyStimulus(2, 1, 6);
        checkSticky("high2", 3, 2, 1, 3);

        applyStimulus(0, 300, 1);
        checkSticky("timeout", 3, 2, 0, 4);

        applyStimulus(1, 4, 2);
        applyStimulus(1, 2, 6);
        checkSticky("after_to", 3, 1, 1, 6);

        applyStimulus(1, 254, 2);
        applyStimulus(1, 255, 1);
        applyStimulus(0, 10, 1);
        checkSticky("sat_edge", 255, 1, 0, 9);

        applyStimulus(1, 2, 6);
        applyStimulus(1, 1, 1);
        doReset(3);
        @(negedge clk);
        checkSticky("mid_reset", 0, 0, 0, 0);
        applyStimulus(1, 2, 3);

        applyStimulus(1, 5, 20);
        applyStimulus(1, 2, 1);
        checkSticky("err_sat", 6, 1, 0, 15);

        applyStimulus(0, 6, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
